// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants, state encoding and address-width helper for the IF stage
package if_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Word-address width for a memory of the given depth
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/instr_ram.sv
// rtl/instr_ram.sv - instruction word array, one synchronous write port and one registered read port
module instr_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = 8
) (
    input  logic             i_clock,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store a packed word from the loader
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; output holds while the read enable is low
    always_ff @(posedge i_clock) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - IF-stage instruction memory with byte-stream loader and fetch range check
module instruction_memory
    import if_pkg::*;
#(
    parameter  int MEM_DEPTH = 256,
    parameter  int PC_SIZE   = 32,
    parameter  int INST_SIZE = 32,
    localparam int ADDR_W    = addr_w(MEM_DEPTH)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [PC_SIZE-1:0]   i_pc,
    input  logic                 i_wr_en,
    input  logic [7:0]           i_wr_byte,
    input  logic                 i_clear,
    output logic [INST_SIZE-1:0] o_instruction,
    output logic                 o_loaded,
    output logic [ADDR_W:0]      o_wr_count,
    output logic                 o_addr_error,
    output logic                 o_halt
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [1:0]             r_byte_cnt;
    logic [23:0]            r_byte_buf;
    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W:0]        r_wr_count;
    logic                   r_inst_valid;
    logic                   r_addr_error;
    logic [INST_SIZE-1:0]   w_rd_data;

    logic                   w_load_byte;
    logic                   w_word_done;
    logic [INST_SIZE-1:0]   w_word;
    logic                   w_last_slot;
    logic                   w_fetch;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic                   w_fetch_bad;

    assign w_load_byte = (r_state == ST_LOAD) && i_wr_en && !i_clear;
    assign w_word_done = w_load_byte && (r_byte_cnt == 2'd3);
    assign w_word      = {r_byte_buf, i_wr_byte};
    assign w_last_slot = (r_wr_ptr == ADDR_W'(MEM_DEPTH - 1));

    assign w_fetch     = (r_state == ST_READY) && i_enable && !i_clear;
    assign w_rd_addr   = i_pc[ADDR_W+1:2];
    assign w_fetch_bad = (|i_pc[1:0])
                       || (|i_pc[PC_SIZE-1:ADDR_W+2])
                       || ({1'b0, w_rd_addr} >= r_wr_count);

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Leave LOAD once a HALT word lands or the last slot is written; clear always returns to LOAD
    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = ST_LOAD;
        end else if (w_word_done && ((w_word == HALT_WORD) || w_last_slot)) begin
            w_next_state = ST_READY;
        end
    end

    // Big-endian byte packer; a partial word is dropped on clear
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_byte_cnt <= 2'd0;
            r_byte_buf <= 24'd0;
        end else if (i_clear) begin
            r_byte_cnt <= 2'd0;
            r_byte_buf <= 24'd0;
        end else if (w_load_byte) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_byte_buf <= {r_byte_buf[15:0], i_wr_byte};
        end
    end

    // Write pointer saturates at the last slot; the count reaches MEM_DEPTH
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
        end else if (w_word_done) begin
            r_wr_count <= r_wr_count + 1'b1;
            if (!w_last_slot) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Fetch status: valid selects RAM data, otherwise the output reads as NOP
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_inst_valid <= 1'b0;
            r_addr_error <= 1'b0;
        end else if (i_clear) begin
            r_inst_valid <= 1'b0;
            r_addr_error <= 1'b0;
        end else if (w_fetch) begin
            r_inst_valid <= !w_fetch_bad;
            r_addr_error <= w_fetch_bad;
        end
    end

    instr_ram #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (INST_SIZE),
        .AW    (ADDR_W)
    ) u_ram (
        .i_clock   (i_clock),
        .i_wr_en   (w_word_done),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_word),
        .i_rd_en   (w_fetch && !w_fetch_bad),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign o_instruction = r_inst_valid ? w_rd_data : NOP_WORD;
    assign o_addr_error  = r_addr_error;
    assign o_loaded      = (r_state == ST_READY);
    assign o_wr_count    = r_wr_count;
    assign o_halt        = (o_instruction == HALT_WORD);

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - self-checking bench for instruction_memory
module tb_instruction_memory;

    localparam int DEPTH = 256;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        i_enable;
    logic [31:0] i_pc;
    logic        i_wr_en;
    logic [7:0]  i_wr_byte;
    logic        i_clear;
    logic [31:0] o_instruction;
    logic        o_loaded;
    logic [8:0]  o_wr_count;
    logic        o_addr_error;
    logic        o_halt;

    int checks;
    int failures;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_count;
    int          m_nbytes;
    logic [31:0] m_word;
    bit          m_loaded;
    logic [31:0] m_inst;
    bit          m_err;

    instruction_memory dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_enable      (i_enable),
        .i_pc          (i_pc),
        .i_wr_en       (i_wr_en),
        .i_wr_byte     (i_wr_byte),
        .i_clear       (i_clear),
        .o_instruction (o_instruction),
        .o_loaded      (o_loaded),
        .o_wr_count    (o_wr_count),
        .o_addr_error  (o_addr_error),
        .o_halt        (o_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_restart();
        m_count  = 0;
        m_nbytes = 0;
        m_word   = 0;
        m_loaded = 0;
        m_inst   = NOP;
        m_err    = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_loaded) begin
            m_word = {m_word[23:0], b};
            m_nbytes++;
            if (m_nbytes == 4) begin
                m_mem[m_count] = m_word;
                m_count++;
                m_nbytes = 0;
                if (m_word == HALT || m_count == DEPTH) m_loaded = 1;
            end
        end
    endtask

    task automatic model_fetch(input logic [31:0] pc, input bit en);
        if (m_loaded && en) begin
            if (pc % 4 != 0 || pc >= 32'(4 * DEPTH) || pc / 4 >= 32'(m_count)) begin
                m_inst = NOP;
                m_err  = 1;
            end else begin
                m_inst = m_mem[pc / 4];
                m_err  = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".inst"},  o_instruction, m_inst);
        chk({tag, ".err"},   32'(o_addr_error), 32'(m_err));
        chk({tag, ".loaded"}, 32'(o_loaded), 32'(m_loaded));
        chk({tag, ".count"}, 32'(o_wr_count), 32'(m_count));
        chk({tag, ".halt"},  32'(o_halt), 32'(m_inst == HALT));
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_wr_en   = 1'b1;
        i_wr_byte = b;
        tick();
        i_wr_en   = 1'b0;
        model_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
    endtask

    task automatic do_clear(input bit with_byte, input logic [7:0] b);
        i_clear   = 1'b1;
        i_wr_en   = with_byte;
        i_wr_byte = b;
        tick();
        i_clear   = 1'b0;
        i_wr_en   = 1'b0;
        model_restart();
    endtask

    task automatic do_fetch(input logic [31:0] pc, input bit en);
        i_pc     = pc;
        i_enable = en;
        tick();
        i_enable = 1'b0;
        model_fetch(pc, en);
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          en;
        logic [31:0] inst;
        bit          err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; i_enable = 0; i_pc = 0; i_wr_en = 0; i_wr_byte = 0; i_clear = 0;
        model_restart();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

        vecs[0] = '{32'd0,         1'b1, 32'h2008_0005, 1'b0};
        vecs[1] = '{32'd4,         1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{32'd2,         1'b1, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'd8,         1'b1, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'd4,         1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{32'd0,         1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{32'd1024,      1'b1, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'd0,         1'b1, 32'h2008_0005, 1'b0};
        vecs[8] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b1};
        vecs[9] = '{32'd3,         1'b0, 32'h0000_0000, 1'b1};

        #12;
        chk("rst.inst",   o_instruction, NOP);
        chk("rst.loaded", 32'(o_loaded), 0);
        chk("rst.count",  32'(o_wr_count), 0);
        chk("rst.err",    32'(o_addr_error), 0);
        chk("rst.halt",   32'(o_halt), 0);
        rst_n = 1'b1;
        tick();

        // Basic program load, then table-driven fetches
        send_word(32'h2008_0005);
        chk("load.w1.loaded", 32'(o_loaded), 0);
        send_word(HALT);
        chk("load.count", 32'(o_wr_count), 2);
        chk("load.loaded", 32'(o_loaded), 1);
        chk("load.inst_nop", o_instruction, NOP);
        for (int i = 0; i < 10; i++) begin
            do_fetch(vecs[i].pc, vecs[i].en);
            chk($sformatf("vec%0d.inst", i), o_instruction, vecs[i].inst);
            chk($sformatf("vec%0d.err", i), 32'(o_addr_error), 32'(vecs[i].err));
            chk($sformatf("vec%0d.halt", i), 32'(o_halt), 32'(vecs[i].inst == HALT));
        end
        send_byte(8'h11);
        chk("ready.byte_ignored", 32'(o_wr_count), 2);

        // Partial word discarded by clear
        do_clear(1'b0, 8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        do_clear(1'b0, 8'h00);
        chk("clr.count", 32'(o_wr_count), 0);
        chk("clr.loaded", 32'(o_loaded), 0);
        send_word(32'h2001_0007);
        send_word(HALT);
        do_fetch(32'd0, 1'b1);
        chk("clr.word0", o_instruction, 32'h2001_0007);

        // Clear and byte strobe in the same cycle: byte dropped, packer restarts
        do_clear(1'b0, 8'h00);
        send_byte(8'hAA);
        do_clear(1'b1, 8'hBB);
        send_word(32'h1234_5678);
        send_word(HALT);
        do_fetch(32'd0, 1'b1);
        chk("clrwr.word0", o_instruction, 32'h1234_5678);
        chk("clrwr.count", 32'(o_wr_count), 2);

        // Fill the whole memory without a HALT word
        do_clear(1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            send_word(32'(i) * 32'h0101_0101 + 32'h10);
            if (i == DEPTH - 2) chk("fill.not_yet", 32'(o_loaded), 0);
        end
        chk("fill.loaded", 32'(o_loaded), 1);
        chk("fill.count", 32'(o_wr_count), DEPTH);
        send_word(32'hDEAD_BEEF);
        chk("fill.extra_count", 32'(o_wr_count), DEPTH);
        do_fetch(32'd4 * (DEPTH - 1), 1'b1);
        chk("fill.last", o_instruction, 32'(DEPTH - 1) * 32'h0101_0101 + 32'h10);
        do_fetch(32'd0, 1'b1);
        chk("fill.first", o_instruction, 32'h10);

        // Asynchronous reset between bytes 2 and 3 of the second word
        do_clear(1'b0, 8'h00);
        send_word(32'h0A0B_0C0D);
        send_byte(8'h01); send_byte(8'h02);
        #3 rst_n = 1'b0;
        #1;
        chk("arst.count", 32'(o_wr_count), 0);
        chk("arst.loaded", 32'(o_loaded), 0);
        chk("arst.inst", o_instruction, NOP);
        chk("arst.err", 32'(o_addr_error), 0);
        #1 rst_n = 1'b1;
        model_restart();
        tick();
        send_word(32'h0303_0404);
        send_word(HALT);
        check_all("arst.reload");
        do_fetch(32'd0, 1'b1);
        chk("arst.word0", o_instruction, 32'h0303_0404);

        // Randomized loads and fetches against the reference model
        for (int r = 0; r < 6; r++) begin
            int n;
            do_clear(1'b0, 8'h00);
            check_all("rnd.clr");
            n = $urandom_range(1, 20);
            for (int w = 0; w < n; w++) begin
                logic [31:0] rw;
                rw = $urandom;
                for (int k = 3; k >= 0; k--) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send_byte(rw[k*8 +: 8]);
                end
            end
            do_fetch(32'd0, 1'b1);
            check_all("rnd.preload");
            if (!m_loaded) send_word(HALT);
            check_all("rnd.loaded");
            for (int f = 0; f < 40; f++) begin
                logic [31:0] pc;
                case ($urandom_range(0, 3))
                    0: pc = 32'($urandom_range(0, m_count + 2)) * 4;
                    1: pc = 32'($urandom_range(0, m_count)) * 4 + 32'($urandom_range(1, 3));
                    2: pc = $urandom;
                    default: pc = 32'($urandom_range(0, m_count - 1)) * 4;
                endcase
                do_fetch(pc, ($urandom_range(0, 4) != 0));
                check_all($sformatf("rnd%0d.f%0d", r, f));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
